// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//
// SHA-256 message schedule generator and round sequencer for one 512-bit
// block. A 16-word sliding window holds W_t..W_t+15. Each accepted advance
// shifts the window by one word and appends W_t+16. The round index drives
// the K-constant ROM, and w feeds the round adder.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   load block and begin round 0 (aborts a block in flight)
//   block      in 512   message block, block[511:480] = M0 ... block[31:0] = M15
//   advance    in   1   consume current W and step to the next round
//   round_idx  out  6   current round t (0..63)
//   w          out 32   schedule word W_t
//   busy       out  1   block in progress; round_idx/w are valid
//   done       out  1   one-cycle pulse after round 63 is consumed
//
// Handshake: round_idx/w are offered whenever busy=1. An edge with busy=1
// and advance=1 consumes the offered word. Holding advance low stalls with
// the outputs held. start takes precedence over advance in every state, and
// advance is ignored while busy=0. All outputs come straight from registers.
//
// Build option: define SHA256_WSCHED_ZEROIZE_EN to clear the window on
// completion, so no message data stays resident in IDLE.
//
// FSM visibility: busy is a direct decode of the state register
// (IDLE -> 0, RUN -> 1).
// -----------------------------------------------------------------------------
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] block,
  input  logic         advance,
  output logic [5:0]   round_idx,
  output logic [31:0]  w,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] window_q [16];
  logic [31:0] window_d [16];
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // window[k] holds W_{t+k}, so the appended word W_{t+16} is formed from
  // W_{t+14}, W_{t+9}, W_{t+1} and W_t.
  assign w_next = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      window_d[i] = window_q[i];
    end

    if (start) begin
      // Reload overwrites every window word in the same edge, so an abort
      // never leaves data from the previous block behind in either build.
      state_d = S_RUN;
      cnt_d   = 6'd0;
      for (int i = 0; i < 16; i++) begin
        window_d[i] = block[511 - 32*i -: 32];
      end
    end else if (state_q == S_RUN && advance) begin
      if (cnt_q == 6'd63) begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
        done_d  = 1'b1;
`ifdef SHA256_WSCHED_ZEROIZE_EN
        for (int i = 0; i < 16; i++) begin
          window_d[i] = 32'd0;
        end
`else
        // Window keeps its last contents; w is don't-care while idle.
`endif
      end else begin
        for (int i = 0; i < 15; i++) begin
          window_d[i] = window_q[i+1];
        end
        window_d[15] = w_next;
        cnt_d        = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) begin
        window_q[i] <= window_d[i];
      end
    end
  end

  assign w         = window_q[0];
  assign round_idx = cnt_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;

endmodule
